instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Wishbone master that fetches 32-bit instructions from the instruction ROM and presents them to decode through a valid/ready interface.
- Holds the fetch PC and a small prefetch FIFO of {pc, instr} pairs.
- Accepts redirects (branch/jump) from execute.
- Sits directly upstream of the ROM slave and downstream of the execute redirect path.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, prefetch entries; power of two, at least 2.
- TIMEOUT_CYCLES, 16, bus cycles without ack before a fault (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- wishbone  interface  -  wishbone_if.master; drives cycle, strobe, address[31:0]; samples ack and data_out[31:0] from the slave; write enable (if present) driven 0.
- redirect_valid  input  1  single-cycle request to restart fetch.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 0.
- instr_valid  output  1  FIFO head valid.
- instr  output  32  FIFO head instruction.
- instr_pc  output  32  FIFO head address.
- instr_ready  input  1  decode accepts the head this cycle.
- fetch_fault  output  1  bus timeout flag; constant 0 unless the optional feature is compiled in.

Behaviour:
- Reset (reset==0 at a clk edge):
  - cycle=0, strobe=0, address=0, pc=RESET_PC, FIFO empty.
  - instr_valid=0, instr=0, instr_pc=0, fetch_fault=0.
  - discard=0, state=IDLE.
  - Reset mid-transaction abandons it; any later ack is ignored because state is IDLE.
- FSM states: IDLE, BUS, FAULT (FAULT exists only with the macro).
- IDLE:
  - If no redirect and (fifo_count + 0) < FIFO_DEPTH, then next edge: cycle=strobe=1, address=pc, state=BUS.
  - Otherwise hold cycle=strobe=0.
- BUS:
  - Hold cycle, strobe and address stable until ack==1.
  - On the ack cycle: if discard==0, push {address, data_out} and pc<=pc+4 (32-bit wrap, 0xFFFFFFFC+4=0).
  - Same edge: clear discard, cycle=strobe=0, state=IDLE.
  - Strobe must be low for at least one cycle after each ack; the slave re-arms from idle, so no back-to-back strobe.
  - Against the ROM (2-cycle slave latency): ack is visible 2 cycles after the strobe-rising edge. Steady-state throughput is one word per 4 cycles.
- FIFO:
  - Registered outputs from the head entry; instr_valid = count!=0.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle keep the count.
  - Issue is blocked while count==FIFO_DEPTH.
  - Only one transaction is ever outstanding, so a push never overflows.
- Redirect (highest priority):
  - Flush the FIFO; instr_valid=0 the following cycle; any pop in that cycle is void.
  - pc<={redirect_pc[31:2],2'b00}.
  - If in BUS and ack not present this cycle: set discard=1. The transaction runs to its ack and its data is dropped; it is never aborted.
  - If ack coincides with redirect: data dropped, state=IDLE.
  - The next fetch issues from IDLE at redirect_pc.
  - Redirect while in FAULT clears fault, state=IDLE.
- fetch_fault and instr_* outputs never glitch mid-cycle; all are registers.

Optional Feature:
- Macro: IFU_BUS_TIMEOUT_EN.
- With the macro:
  - A counter counts cycles in BUS and resets on entry.
  - If it reaches TIMEOUT_CYCLES without ack: next edge cycle=strobe=0, fetch_fault=1, state=FAULT.
  - FAULT issues nothing; the FIFO keeps draining normally.
  - Exit FAULT only via redirect or reset.
- Without the macro: no counter, no FAULT state, fetch_fault tied 0, BUS waits indefinitely.

Test Plan:
- Reset release with ROM model word0=0x00000093, word1=0x0000DEAD, instr_ready=1 -> strobe rises 1 cycle after release, address=0x0, ack 2 cycles later; instr_valid with instr=0x00000093, instr_pc=0x0; next fetch address=0x4, returns 0x0000DEAD.
- instr_ready=0 for 20 cycles -> exactly FIFO_DEPTH=2 fetches (0x0, 0x4); cycle stays 0 afterwards; raising ready delivers 0x0 then 0x4, then fetching resumes at 0x8.
- Redirect to 0x0000_0102 one cycle after strobe rises at 0x8 -> data from 0x8 not pushed; next strobe has address=0x100; first instr_pc=0x100.
- Redirect coincident with ack and with a pop, FIFO holding one entry -> instr_valid=0 next cycle, ack data dropped, next address=redirect target.
- reset driven 0 while in BUS, slave acks later -> no push, instr_valid stays 0, fetch restarts at RESET_PC after release.
- With IFU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks -> strobe drops after 16 BUS cycles, fetch_fault=1 and held; redirect to 0x0 clears fault and fetch resumes.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Wishbone bus bundle between the instruction fetch unit (master) and the
// instruction ROM (slave). Classic single-transfer cycle/strobe/ack handshake.
interface wishbone_if;
    logic        cycle;
    logic        strobe;
    logic        write_enable;
    logic [31:0] address;
    logic        ack;
    logic [31:0] data_out;

    modport master (
        output cycle, strobe, write_enable, address,
        input  ack, data_out
    );

    modport slave (
        input  cycle, strobe, write_enable, address,
        output ack, data_out
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: Wishbone master that reads 32-bit words from the
// instruction ROM into a small prefetch FIFO of {pc, instr} pairs and hands
// them to decode over valid/ready. Execute can redirect fetch at any time.
// Optional feature: define IFU_BUS_TIMEOUT_EN to add a bus timeout that
// raises fetch_fault and parks the unit in FAULT until a redirect or reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          FIFO_DEPTH     = 2,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    wishbone_if.master  wishbone,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fetch_fault
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

`ifdef IFU_BUS_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUS = 2'd1, ST_FAULT = 2'd2} state_t;
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_r;
    logic             fault_r;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUS = 2'd1} state_t;
`endif

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] adr_r;
    logic        cyc_r;
    logic        stb_r;
    logic        discard_r;

    // Prefetch storage and its next-state view
    logic [31:0]      mem_pc_r  [FIFO_DEPTH];
    logic [31:0]      mem_ins_r [FIFO_DEPTH];
    logic [31:0]      mem_pc_n  [FIFO_DEPTH];
    logic [31:0]      mem_ins_n [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r, rd_ptr_n;
    logic [PTR_W-1:0] wr_ptr_r, wr_ptr_n;
    logic [CNT_W-1:0] count_r, count_n;
    logic [31:0]      head_pc_n, head_ins_n;

    logic        instr_valid_r;
    logic [31:0] instr_r;
    logic [31:0] instr_pc_r;

    logic        ack_s;
    logic [31:0] data_s;
    logic        push_s;
    logic        pop_s;
    logic        unused_cfg_s;

    assign ack_s  = wishbone.ack;
    assign data_s = wishbone.data_out;

    // A completed read is kept only if it was not orphaned by a redirect.
    assign push_s = (state_r == ST_BUS) && ack_s && !discard_r && !redirect_valid;
    // A redirect flushes the FIFO, so any hand-off in that cycle is void.
    assign pop_s  = instr_valid_r && instr_ready && !redirect_valid;

    assign wishbone.cycle        = cyc_r;
    assign wishbone.strobe       = stb_r;
    assign wishbone.address      = adr_r;
    assign wishbone.write_enable = 1'b0;

    assign instr_valid = instr_valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;

`ifdef IFU_BUS_TIMEOUT_EN
    assign fetch_fault = fault_r;
`else
    assign fetch_fault = 1'b0;
`endif

    // Word alignment drops the redirect low bits; TIMEOUT_CYCLES is only used with the bus timeout.
    assign unused_cfg_s = ^{redirect_pc[1:0], 32'(TIMEOUT_CYCLES)};

    // Next FIFO contents, pointers and head view after this cycle's push/pop/flush
    always_comb begin
        mem_pc_n   = mem_pc_r;
        mem_ins_n  = mem_ins_r;
        rd_ptr_n   = rd_ptr_r;
        wr_ptr_n   = wr_ptr_r;
        count_n    = count_r;
        head_pc_n  = 32'h0000_0000;
        head_ins_n = 32'h0000_0000;
        if (redirect_valid) begin
            rd_ptr_n = {PTR_W{1'b0}};
            wr_ptr_n = {PTR_W{1'b0}};
            count_n  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_pc_n[wr_ptr_r]  = adr_r;
                mem_ins_n[wr_ptr_r] = data_s;
                wr_ptr_n            = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_n = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_n = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_n = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_n = count_r + CNT_ONE;
                2'b01:   count_n = count_r - CNT_ONE;
                default: count_n = count_r;
            endcase
        end
        if (count_n != {CNT_W{1'b0}}) begin
            head_pc_n  = mem_pc_n[rd_ptr_n];
            head_ins_n = mem_ins_n[rd_ptr_n];
        end else begin
            head_pc_n  = 32'h0000_0000;
            head_ins_n = 32'h0000_0000;
        end
    end

    // FIFO state and registered decode-facing head outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_pc_r[i]  <= 32'h0000_0000;
                mem_ins_r[i] <= 32'h0000_0000;
            end
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            instr_valid_r <= 1'b0;
            instr_r       <= 32'h0000_0000;
            instr_pc_r    <= 32'h0000_0000;
        end else begin
            mem_pc_r      <= mem_pc_n;
            mem_ins_r     <= mem_ins_n;
            rd_ptr_r      <= rd_ptr_n;
            wr_ptr_r      <= wr_ptr_n;
            count_r       <= count_n;
            instr_valid_r <= (count_n != {CNT_W{1'b0}});
            instr_r       <= head_ins_n;
            instr_pc_r    <= head_pc_n;
        end
    end

    // Fetch PC: redirect wins, otherwise advance by one word per kept read (wraps at 2^32)
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r <= {RESET_PC[31:2], 2'b00};
        end else if (redirect_valid) begin
            pc_r <= {redirect_pc[31:2], 2'b00};
        end else if (push_s) begin
            pc_r <= pc_r + 32'd4;
        end
    end

    // Bus FSM: one outstanding read at a time, strobe low for a cycle after every ack
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            adr_r     <= 32'h0000_0000;
            discard_r <= 1'b0;
`ifdef IFU_BUS_TIMEOUT_EN
            tmo_r     <= {TMO_W{1'b0}};
            fault_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!redirect_valid && (count_r < CNT_FULL)) begin
                        cyc_r   <= 1'b1;
                        stb_r   <= 1'b1;
                        adr_r   <= pc_r;
                        state_r <= ST_BUS;
`ifdef IFU_BUS_TIMEOUT_EN
                        tmo_r   <= {TMO_W{1'b0}};
`endif
                    end else begin
                        cyc_r <= 1'b0;
                        stb_r <= 1'b0;
                    end
                end
                ST_BUS: begin
                    if (ack_s) begin
                        cyc_r     <= 1'b0;
                        stb_r     <= 1'b0;
                        discard_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (redirect_valid) begin
                        // Never abort a live read: let it finish and drop its data.
                        discard_r <= 1'b1;
`ifdef IFU_BUS_TIMEOUT_EN
                        tmo_r     <= tmo_r + TMO_W'(1'b1);
                    end else if (tmo_r == TMO_LAST) begin
                        cyc_r     <= 1'b0;
                        stb_r     <= 1'b0;
                        discard_r <= 1'b0;
                        fault_r   <= 1'b1;
                        state_r   <= ST_FAULT;
                    end else begin
                        tmo_r     <= tmo_r + TMO_W'(1'b1);
`else
                    end else begin
                        discard_r <= discard_r;
`endif
                    end
                end
`ifdef IFU_BUS_TIMEOUT_EN
                ST_FAULT: begin
                    cyc_r <= 1'b0;
                    stb_r <= 1'b0;
                    if (redirect_valid) begin
                        fault_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        fault_r <= 1'b1;
                    end
                end
`endif
                default: begin
                    cyc_r     <= 1'b0;
                    stb_r     <= 1'b0;
                    discard_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROM slave model with variable latency, directed
// scenarios followed by randomized ready/redirect/reset traffic. Expected
// instruction stream is a queue of {pc, rom(pc)} refilled from the model PC.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    wishbone_if wb_bus ();

    instr_fetch_unit #(
        .RESET_PC       (RESET_PC),
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wishbone       (wb_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    int rises = 0;
    logic [31:0] last_rise_addr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0093;
        if (a == 32'h4) return 32'h0000_DEAD;
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC0DE};
    endfunction

    // ROM slave model: accepts a strobe, acks after lat cycles with one pulse
    int   lat_min = 2;
    int   lat_max = 2;
    bit   mute = 1'b0;
    logic busy = 1'b0;
    int   cnt = 0;
    logic [31:0] lat_addr = 32'h0;
    initial begin
        wb_bus.ack = 1'b0;
        wb_bus.data_out = 32'h0;
    end
    always @(posedge clk) begin
        int lat;
        wb_bus.ack <= 1'b0;
        if (busy) begin
            if (cnt <= 1) begin
                wb_bus.ack      <= 1'b1;
                wb_bus.data_out <= rom_word(lat_addr);
                busy            <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (wb_bus.cycle && wb_bus.strobe && !wb_bus.ack && !mute) begin
            lat = $urandom_range(lat_max, lat_min);
            if (lat <= 1) begin
                wb_bus.ack      <= 1'b1;
                wb_bus.data_out <= rom_word(wb_bus.address);
            end else begin
                busy     <= 1'b1;
                cnt      <= lat - 1;
                lat_addr <= wb_bus.address;
            end
        end
    end

    // Reference stream: successive words from the last reset/redirect target
    logic [63:0] exp_q[$];
    logic [31:0] model_pc = 32'h0;

    function automatic void top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back({model_pc, rom_word(model_pc)});
            model_pc = model_pc + 32'd4;
        end
    endfunction

    function automatic void restart_stream(input logic [31:0] target);
        exp_q.delete();
        model_pc = {target[31:2], 2'b00};
        top_up();
    endfunction

    // Monitor: scoreboard on every accepted hand-off plus bus protocol checks
    logic        prev_ack = 1'b0;
    logic        prev_stb = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (reset && instr_valid && instr_ready && !redirect_valid) begin
                e = exp_q.pop_front();
                check("instr_pc", instr_pc, e[63:32]);
                check("instr", instr, e[31:0]);
                delivered++;
                top_up();
            end
            if (prev_ack) check("strobe_gap_after_ack", 32'(wb_bus.strobe), 32'd0);
            if (prev_stb && !prev_ack && wb_bus.strobe)
                check("address_stable", wb_bus.address, prev_addr);
            if (wb_bus.strobe && !prev_stb) begin
                rises++;
                last_rise_addr = wb_bus.address;
                check("cycle_with_strobe", 32'(wb_bus.cycle), 32'd1);
                check("write_enable_low", 32'(wb_bus.write_enable), 32'd0);
`ifndef IFU_BUS_TIMEOUT_EN
                check("fetch_fault_tied", 32'(fetch_fault), 32'd0);
`endif
            end
            prev_ack  = wb_bus.ack;
            prev_stb  = wb_bus.strobe;
            prev_addr = wb_bus.address;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input string name, input logic [31:0] req);
        int start;
        int n;
        start = rises;
        n = 0;
        while (rises == start && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rises == start) begin
            checks++;
            errors++;
            $display("FAIL %s: no strobe within 100 cycles, required address=0x%08h", name, req);
        end else begin
            check(name, last_rise_addr, req);
        end
    endtask

    task automatic do_reset(input int hold);
        redirect_valid = 1'b0;
        reset = 1'b0;
        restart_stream(RESET_PC);
        repeat (hold) step();
        reset = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        restart_stream(target);
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int base;
        int n;
        restart_stream(RESET_PC);
        instr_ready = 1'b1;

        // Reset state and first fetches
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cycle", 32'(wb_bus.cycle), 32'd0);
        check("rst_strobe", 32'(wb_bus.strobe), 32'd0);
        check("rst_address", wb_bus.address, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("strobe_before_issue", 32'(wb_bus.strobe), 32'd0);
        @(negedge clk);
        check("strobe_one_after_release", 32'(wb_bus.strobe), 32'd1);
        check("first_address", wb_bus.address, 32'h0);
        @(negedge clk);
        check("ack_not_yet", 32'(wb_bus.ack), 32'd0);
        @(negedge clk);
        check("ack_two_after_strobe", 32'(wb_bus.ack), 32'd1);
        wait_rise("second_fetch_addr", 32'h4);
        repeat (8) step();

        // Decode stalled: FIFO fills with exactly two words, then drains in order
        instr_ready = 1'b0;
        step();
        do_reset(4);
        base = rises;
        repeat (20) step();
        check("fill_fetch_count", 32'(rises - base), 32'd2);
        check("cycle_idle_when_full", 32'(wb_bus.cycle), 32'd0);
        check("full_head_valid", 32'(instr_valid), 32'd1);
        check("full_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        wait_rise("resume_addr", 32'h8);

        // Redirect one cycle after the strobe at 0x8 rises
        step();
        do_redirect(32'h0000_0102);
        check("flush_valid_low", 32'(instr_valid), 32'd0);
        wait_rise("redirect_addr", 32'h100);

        // Redirect coincident with ack and pop while one entry is held
        step();
        instr_ready = 1'b0;
        do_redirect(32'h0000_0200);
        wait_rise("stall_first_addr", 32'h200);
        wait_rise("stall_second_addr", 32'h204);
        n = 0;
        do begin
            step();
            n++;
        end while (!wb_bus.ack && n < 20);
        check("one_entry_valid", 32'(instr_valid), 32'd1);
        check("one_entry_pc", instr_pc, 32'h200);
        instr_ready = 1'b1;
        do_redirect(32'h0000_0300);
        check("flush_on_ack_valid", 32'(instr_valid), 32'd0);
        wait_rise("ack_redirect_addr", 32'h300);

        // Reset in the middle of a bus transaction; the late ack is ignored
        wait_rise("pre_reset_addr", 32'h304);
        step();
        reset = 1'b0;
        restart_stream(RESET_PC);
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_cycle_low", 32'(wb_bus.cycle), 32'd0);
            check("reset_valid_low", 32'(instr_valid), 32'd0);
        end
        reset = 1'b1;
        wait_rise("restart_addr", RESET_PC);

        // Address wrap past the top of the 32-bit space
        repeat (3) step();
        do_redirect(32'hFFFF_FFF9);
        wait_rise("wrap_first_addr", 32'hFFFF_FFF8);
        repeat (30) step();

        // Randomized traffic
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset(6);
            end else if ($urandom_range(0, 39) == 0) begin
                do_redirect($urandom);
            end else begin
                step();
            end
        end
        instr_ready = 1'b1;
        repeat (20) step();
        check("delivered_enough", 32'(delivered > 100), 32'd1);

`ifdef IFU_BUS_TIMEOUT_EN
        // Silent slave: strobe drops after 16 bus cycles and fault latches
        lat_min = 2;
        lat_max = 2;
        instr_ready = 1'b0;
        repeat (30) step();
        mute = 1'b1;
        instr_ready = 1'b1;
        do_redirect(32'h0000_0400);
        wait_rise("timeout_addr", 32'h400);
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            #1;
            if (!wb_bus.strobe) break;
            n++;
        end
        check("timeout_strobe_cycles", 32'(n), 32'd16);
        check("fault_set", 32'(fetch_fault), 32'd1);
        repeat (5) step();
        check("fault_held", 32'(fetch_fault), 32'd1);
        check("fault_no_cycle", 32'(wb_bus.cycle), 32'd0);
        mute = 1'b0;
        do_redirect(32'h0);
        check("fault_cleared", 32'(fetch_fault), 32'd0);
        wait_rise("fault_resume_addr", 32'h0);
        repeat (20) step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
